// File: rtl/rans_decoder.sv
// Streaming rANS decoder: consumes encoder chunks in LIFO order and emits the original symbols.
// Optional build macro RANS_DEC_ERR_EN adds the sticky table-consistency flag err_o.
module rans_decoder #(
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      freq_wr_i,
  input  logic                      restart_i,
  input  logic [RESOLUTION-1:0]     freq_i,
  input  logic [RESOLUTION-1:0]     cum_freq_i,
  input  logic [SYMBOL_WIDTH-1:0]   symb_i,
  output logic                      ready_o,
  input  logic [2*SYMBOL_WIDTH-1:0] chunk_i,
  input  logic                      chunk_valid_i,
  output logic                      chunk_ready_o,
  output logic [SYMBOL_WIDTH-1:0]   symb_o,
  output logic                      symb_valid_o,
  input  logic                      symb_ready_i
`ifdef RANS_DEC_ERR_EN
  ,
  output logic                      err_o
`endif
);

  localparam int unsigned CW    = 2 * SYMBOL_WIDTH;
  localparam int unsigned XW    = 4 * SYMBOL_WIDTH;
  localparam int unsigned NSYM  = 1 << SYMBOL_WIDTH;
  localparam int unsigned NSLOT = 1 << RESOLUTION;

  typedef enum logic [3:0] {
    S_CFG, S_FILL, S_INIT_HI, S_INIT_LO, S_LOOK, S_FETCH, S_CALC, S_EMIT, S_RENORM
  } state_t;

  state_t state_q, state_d;

  logic [RESOLUTION-1:0]   freq_mem [NSYM];
  logic [RESOLUTION-1:0]   cum_mem  [NSYM];
  logic [SYMBOL_WIDTH-1:0] slot_mem [NSLOT];

  logic [XW-1:0]           x_q;
  logic [SYMBOL_WIDTH-1:0] slot_rd_q;
  logic [RESOLUTION-1:0]   freq_rd_q;
  logic [RESOLUTION-1:0]   cum_rd_q;
  logic [RESOLUTION-1:0]   fill_addr_q;
  logic [RESOLUTION-1:0]   fill_left_q;
  logic [SYMBOL_WIDTH-1:0] fill_sym_q;

  logic tbl_wr;
  logic start;
  logic fill_wr;
  logic x_below_l;

  assign x_below_l = (x_q[XW-1:CW] == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_CFG;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ready_o       = 1'b0;
    chunk_ready_o = 1'b0;
    symb_valid_o  = 1'b0;
    tbl_wr        = 1'b0;
    start         = 1'b0;
    fill_wr       = 1'b0;
    case (state_q)
      S_CFG: begin
        ready_o = 1'b1;
        if (freq_wr_i) begin
          tbl_wr = 1'b1;
          if (freq_i != '0) state_d = S_FILL;
        end else if (en_i) begin
          start   = 1'b1;
          state_d = S_INIT_HI;
        end
      end
      S_FILL: begin
        fill_wr = 1'b1;
        if (fill_left_q == RESOLUTION'(1)) state_d = S_CFG;
      end
      S_INIT_HI: begin
        chunk_ready_o = 1'b1;
        if (chunk_valid_i) state_d = S_INIT_LO;
      end
      S_INIT_LO: begin
        chunk_ready_o = 1'b1;
        if (chunk_valid_i) state_d = S_LOOK;
      end
      S_LOOK:  state_d = S_FETCH;
      S_FETCH: state_d = S_CALC;
      S_CALC:  state_d = S_EMIT;
      S_EMIT: begin
        symb_valid_o = 1'b1;
        if (symb_ready_i) state_d = x_below_l ? S_RENORM : S_LOOK;
      end
      S_RENORM: begin
        chunk_ready_o = 1'b1;
        if (chunk_valid_i) state_d = S_LOOK;
      end
      default: state_d = S_CFG;
    endcase
    // Abort suppresses every side effect of the current cycle, not just the transition.
    if (restart_i || rst_i) begin
      state_d = S_CFG;
      tbl_wr  = 1'b0;
      start   = 1'b0;
      fill_wr = 1'b0;
    end
  end

  // Table RAMs: no reset, continuous 1-cycle reads; LOOK/FETCH give each read one cycle to land.
  always_ff @(posedge clk_i) begin
    if (tbl_wr) begin
      freq_mem[symb_i] <= freq_i;
      cum_mem[symb_i]  <= cum_freq_i;
    end
    if (fill_wr) slot_mem[fill_addr_q] <= fill_sym_q;
    slot_rd_q <= slot_mem[x_q[RESOLUTION-1:0]];
    freq_rd_q <= freq_mem[slot_rd_q];
    cum_rd_q  <= cum_mem[slot_rd_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q         <= '0;
      symb_o      <= '0;
      fill_addr_q <= '0;
      fill_left_q <= '0;
      fill_sym_q  <= '0;
    end else if (!restart_i) begin
      case (state_q)
        S_CFG: begin
          if (tbl_wr) begin
            fill_addr_q <= cum_freq_i;
            fill_left_q <= freq_i;
            fill_sym_q  <= symb_i;
          end
        end
        S_FILL: begin
          fill_addr_q <= fill_addr_q + 1'b1;
          fill_left_q <= fill_left_q - 1'b1;
        end
        S_INIT_HI: if (chunk_valid_i) x_q[XW-1:CW] <= chunk_i;
        S_INIT_LO: if (chunk_valid_i) x_q[CW-1:0]  <= chunk_i;
        S_CALC: begin
          x_q    <= XW'(freq_rd_q) * (x_q >> RESOLUTION)
                    + XW'(x_q[RESOLUTION-1:0]) - XW'(cum_rd_q);
          symb_o <= slot_rd_q;
        end
        S_RENORM: if (chunk_valid_i) x_q <= {x_q[CW-1:0], chunk_i};
        default: ;
      endcase
    end
  end

`ifdef RANS_DEC_ERR_EN
  localparam logic [RESOLUTION:0] M_TOT = {1'b1, {RESOLUTION{1'b0}}};

  logic [RESOLUTION:0] freq_sum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      err_o      <= 1'b0;
      freq_sum_q <= '0;
    end else begin
      if (tbl_wr) begin
        freq_sum_q <= freq_sum_q + {1'b0, freq_i};
        if (({1'b0, cum_freq_i} + {1'b0, freq_i}) > M_TOT) err_o <= 1'b1;
      end
      if (start && (freq_sum_q != M_TOT)) err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rans_decoder.sv
// Self-checking bench for rans_decoder: directed scenarios plus a randomized round trip
// against a division-based rANS encoder model; err_o checks compile in with RANS_DEC_ERR_EN.
module tb_rans_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        freq_wr_i = 1'b0;
  logic        restart_i = 1'b0;
  logic [9:0]  freq_i = '0;
  logic [9:0]  cum_freq_i = '0;
  logic [7:0]  symb_i = '0;
  logic        ready_o;
  logic [15:0] chunk_i = '0;
  logic        chunk_valid_i = 1'b0;
  logic        chunk_ready_o;
  logic [7:0]  symb_o;
  logic        symb_valid_o;
  logic        symb_ready_i = 1'b0;
`ifdef RANS_DEC_ERR_EN
  logic        err_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  rans_decoder #(.RESOLUTION(10), .SYMBOL_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .freq_wr_i(freq_wr_i), .restart_i(restart_i),
    .freq_i(freq_i), .cum_freq_i(cum_freq_i), .symb_i(symb_i), .ready_o(ready_o),
    .chunk_i(chunk_i), .chunk_valid_i(chunk_valid_i), .chunk_ready_o(chunk_ready_o),
    .symb_o(symb_o), .symb_valid_o(symb_valid_o), .symb_ready_i(symb_ready_i)
`ifdef RANS_DEC_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_chunk(input logic [15:0] c, output bit ok);
    ok = 0;
    chunk_valid_i = 1'b1;
    chunk_i = c;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (chunk_ready_o) ok = 1;
      step();
    end
    chunk_valid_i = 1'b0;
  endtask

  task automatic recv_sym(output logic [7:0] s, output bit ok);
    ok = 0;
    s = '0;
    symb_ready_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (symb_valid_o) begin
        ok = 1;
        s = symb_o;
      end
      step();
    end
    symb_ready_i = 1'b0;
  endtask

  task automatic wr_freq(input logic [7:0] s, input int f, input int c, output int lowcnt);
    freq_wr_i = 1'b1;
    symb_i = s;
    freq_i = 10'(f);
    cum_freq_i = 10'(c);
    step();
    freq_wr_i = 1'b0;
    lowcnt = 0;
    while (!ready_o && lowcnt < 2000) begin
      lowcnt++;
      step();
    end
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready_o); end
    vectors++; if (symb_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_symb_valid got %b want 0", symb_valid_o); end
    vectors++; if (chunk_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_chunk_ready got %b want 0", chunk_ready_o); end
    vectors++; if (symb_o !== 8'h00) begin miscompares++; $display("FAIL reset_symb_o got %h want 00", symb_o); end
  endtask

  task automatic test_fill();
    int lowcnt;
    wr_freq(8'h41, 512, 0, lowcnt);
    vectors++; if (lowcnt != 512) begin miscompares++; $display("FAIL fill_A_busy got %0d want 512", lowcnt); end
    // write together with en_i: the write must win
    freq_wr_i = 1'b1; en_i = 1'b1; symb_i = 8'h42; freq_i = 10'd512; cum_freq_i = 10'd512;
    step();
    freq_wr_i = 1'b0; en_i = 1'b0;
    vectors++; if (ready_o !== 1'b0 || chunk_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL fill_wr_beats_en got ready=%b chunk_ready=%b want 0 0", ready_o, chunk_ready_o);
    end
    lowcnt = 0;
    while (!ready_o && lowcnt < 2000) begin lowcnt++; step(); end
    vectors++; if (lowcnt != 512) begin miscompares++; $display("FAIL fill_B_busy got %0d want 512", lowcnt); end
  endtask

  task automatic init_and_first(input string tag);
    bit ok;
    logic [7:0] s;
    en_i = 1'b1; step(); en_i = 1'b0;
    vectors++; if (chunk_ready_o !== 1'b1) begin miscompares++; $display("FAIL %s_init_ready got %b want 1", tag, chunk_ready_o); end
    send_chunk(16'h0001, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_init_hi got timeout want accept", tag); end
    send_chunk(16'h0000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_init_lo got timeout want accept", tag); end
    recv_sym(s, ok);
    vectors++; if (!ok || s !== 8'h41) begin miscompares++; $display("FAIL %s_sym0 got %h ok=%0d want 41", tag, s, ok); end
    vectors++; if (chunk_ready_o !== 1'b1) begin miscompares++; $display("FAIL %s_renorm_req got %b want 1", tag, chunk_ready_o); end
  endtask

  task automatic renorm_and_b(input string tag);
    bit ok;
    logic [7:0] s;
    send_chunk(16'h1234, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_renorm_chunk got timeout want accept", tag); end
    recv_sym(s, ok);
    vectors++; if (!ok || s !== 8'h42) begin miscompares++; $display("FAIL %s_sym1 got %h ok=%0d want 42", tag, s, ok); end
  endtask

  task automatic test_decode_renorm();
    bit taken;
    bit ok;
    logic [7:0] s;
    init_and_first("dec");
    renorm_and_b("dec");
    // x=0x40000834 >= L: next symbol (slot 52 -> 'A') must need no chunk
    taken = 0; ok = 0; s = '0;
    chunk_valid_i = 1'b1; chunk_i = 16'hDEAD; symb_ready_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (chunk_ready_o) taken = 1;
      if (symb_valid_o) begin ok = 1; s = symb_o; end
      step();
    end
    chunk_valid_i = 1'b0; symb_ready_i = 1'b0;
    vectors++; if (taken) begin miscompares++; $display("FAIL dec_no_renorm got chunk_ready=1 want 0"); end
    vectors++; if (!ok || s !== 8'h41) begin miscompares++; $display("FAIL dec_sym2 got %h ok=%0d want 41", s, ok); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] s;
    int bad;
    // x=0x20000434 -> slot 52 -> 'A'
    symb_ready_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (symb_valid_o) ok = 1; else step();
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_valid got timeout want valid"); end
    bad = 0;
    chunk_valid_i = 1'b1; chunk_i = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      if (symb_valid_o !== 1'b1 || symb_o !== 8'h41 || chunk_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got valid=%b symb=%h chunk_ready=%b want 1 41 0", i, symb_valid_o, symb_o, chunk_ready_o);
      end
      step();
    end
    chunk_valid_i = 1'b0;
    vectors++; if (bad != 0) miscompares++;
    recv_sym(s, ok);
    vectors++; if (!ok || s !== 8'h41) begin miscompares++; $display("FAIL bp_release got %h ok=%0d want 41", s, ok); end
  endtask

  task automatic test_restart();
    pulse_restart();
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_cfg got ready=%b want 1", ready_o); end
    init_and_first("rs1");
    chunk_valid_i = 1'b1; chunk_i = 16'h5555;
    pulse_restart();
    chunk_valid_i = 1'b0;
    vectors++; if (ready_o !== 1'b1 || chunk_ready_o !== 1'b0 || symb_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL restart_renorm got ready=%b chunk_ready=%b valid=%b want 1 0 0", ready_o, chunk_ready_o, symb_valid_o);
    end
    init_and_first("rs2");
    renorm_and_b("rs2");
  endtask

  task automatic test_round_trip();
    int f_of[256];
    int c_of[256];
    logic [7:0] alpha[$];
    logic [7:0] msg[$];
    logic [15:0] chunks[$];
    longint unsigned x;
    int nsym, rem, cum, lowcnt, got, cyc, bad, r;
    bit cv, fire_c, fire_s;
    logic [7:0] cand, sym;

    pulse_restart();
    nsym = $urandom_range(2, 12);
    while (alpha.size() < nsym) begin
      cand = 8'($urandom_range(0, 255));
      if (!(cand inside {alpha})) alpha.push_back(cand);
    end
    rem = 1024; cum = 0;
    foreach (alpha[i]) begin
      int f;
      f = (i == nsym - 1) ? rem : $urandom_range(1, rem - (nsym - 1 - i));
      f_of[alpha[i]] = f; c_of[alpha[i]] = cum;
      cum += f; rem -= f;
      wr_freq(alpha[i], f, c_of[alpha[i]], lowcnt);
    end

    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 1023);
      foreach (alpha[k])
        if (r >= c_of[alpha[k]] && r < c_of[alpha[k]] + f_of[alpha[k]]) sym = alpha[k];
      msg.push_back(sym);
    end

    // Encoder: symbols in reverse order, chunks pushed in emission order.
    x = 64'd65536;
    for (int i = 999; i >= 0; i--) begin
      longint unsigned f, c;
      f = longint'(f_of[msg[i]]); c = longint'(c_of[msg[i]]);
      if (x >= (f << 22)) begin chunks.push_back(16'(x & 64'hFFFF)); x = x >> 16; end
      x = ((x / f) << 10) + (x % f) + c;
    end
    chunks.push_back(16'(x & 64'hFFFF));
    chunks.push_back(16'(x >> 16));

    en_i = 1'b1; step(); en_i = 1'b0;
    got = 0; cyc = 0; bad = 0;
    while (got < 1000 && cyc < 30000) begin
      cv = (chunks.size() > 0) && ($urandom_range(0, 3) != 0);
      chunk_valid_i = cv;
      chunk_i = cv ? chunks[$] : 16'h0;
      symb_ready_i = ($urandom_range(0, 3) != 0);
      fire_c = cv && chunk_ready_o;
      fire_s = symb_ready_i && symb_valid_o;
      sym = symb_o;
      step();
      cyc++;
      if (fire_c) void'(chunks.pop_back());
      if (fire_s) begin
        vectors++;
        if (sym !== msg[got]) begin
          miscompares++;
          if (bad < 10) $display("FAIL rt_symbol idx %0d got %h want %h", got, sym, msg[got]);
          bad++;
        end
        got++;
      end
    end
    chunk_valid_i = 1'b0; symb_ready_i = 1'b0;
    vectors++; if (got != 1000) begin miscompares++; $display("FAIL rt_timeout got %0d symbols want 1000", got); end
    vectors++; if (chunks.size() != 0) begin miscompares++; $display("FAIL rt_chunks_left got %0d want 0", chunks.size()); end
  endtask

`ifdef RANS_DEC_ERR_EN
  task automatic test_err();
    int lowcnt;
    pulse_restart();
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", err_o); end
    wr_freq(8'h41, 1000, 0, lowcnt);
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_inrange_wr got %b want 0", err_o); end
    en_i = 1'b1; step(); en_i = 1'b0;
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sum1000 got %b want 1", err_o); end
    pulse_restart();
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_restart got %b want 0", err_o); end
    wr_freq(8'h42, 100, 1000, lowcnt);
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_overrange got %b want 1", err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_decode_renorm();
    test_backpressure();
    test_restart();
    test_round_trip();
`ifdef RANS_DEC_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
